// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP_WORD   = 32'hE1A0_0000;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: imem address/data, redirect request and the decode handshake.
interface ifetch_queue_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_a;
    logic [31:0]       imem_rd;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_a,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry register FIFO of {pc, instr} with flush; head is read combinationally.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  ifq_entry_t       wr_data,
    output ifq_entry_t       rd_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    ifq_entry_t       entry_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            ifq_entry_t entry_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (push && !flush && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= wr_data;
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Flush overrides everything; otherwise push and pop may coincide even when full.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            count_next = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rd_data = entry_q[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, fills a prefetch FIFO from imem and handles redirects.
// Optional perf counters are built when IFETCH_QUEUE_PERF_EN is defined.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    ifetch_queue_if.master     bus
`ifdef IFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic              push, pop, full, empty;
    logic [PTR_W:0]    count;
    ifq_entry_t        wr_entry, head;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a fetch.
    assign pop  = !empty && bus.instr_ready;
    assign push = !bus.redirect_valid && (!full || pop);

    assign wr_entry = '{pc: 32'(fetch_pc_reg), instr: bus.imem_rd};

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (bus.redirect_valid) begin
            fetch_pc_next = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_next = fetch_pc_reg + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_pc_reg <= RESET_PC;
        else       fetch_pc_reg <= fetch_pc_next;
    end

    assign bus.imem_a      = fetch_pc_reg;
    assign bus.instr_valid = !empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = ADDR_W'(head.pc);

`ifdef IFETCH_QUEUE_PERF_EN
    logic [31:0]    fetched_reg, flushed_reg;
    logic [32:0]    flushed_sum;
    logic [PTR_W:0] discard;

    // The entry popped during a redirect belongs to decode, so it is not counted as flushed.
    always_comb begin
        discard     = count - (PTR_W+1)'(pop);
        flushed_sum = {1'b0, flushed_reg} + 33'(discard);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_reg <= '0;
            flushed_reg <= '0;
        end else begin
            if (push && fetched_reg != '1) fetched_reg <= fetched_reg + 1'b1;
            if (bus.redirect_valid) flushed_reg <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign perf_fetched = fetched_reg;
    assign perf_flushed = flushed_reg;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue with a queue-based reference model.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if #(.ADDR_W(32)) bus ();

`ifdef IFETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFETCH_QUEUE_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    // Instruction memory contents as seen by the fetch stage.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE04F_000F;
        if (a == 32'h4) return 32'hE04F_100F;
        if (a == 32'h8) return 32'hE04F_200F;
        if (a == 32'hC) return 32'hE04F_300F;
        if (a[31:8] == 24'h1) return NOP_WORD;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.imem_rd = imem_word(bus.imem_a);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: the expected FIFO contents, the fetch PC and perf totals.
    ifq_entry_t  exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    longint      m_fetched = 0;
    longint      m_flushed = 0;

    // Model: decides at each cycle (after the monitor's pop) what the next edge does.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            exp_q.delete();
            model_pc  = RESET_PC;
            m_fetched = 0;
            m_flushed = 0;
        end else if (bus.redirect_valid) begin
            m_flushed = m_flushed + exp_q.size();
            if (m_flushed > 64'hFFFF_FFFF) m_flushed = 64'hFFFF_FFFF;
            exp_q.delete();
            model_pc = bus.redirect_pc & ~32'h3;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back('{pc: model_pc, instr: imem_word(model_pc)});
            model_pc = model_pc + 32'd4;
            if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
        end
    end

    // Monitor: compares what the DUT presents against the expected queue head.
    always @(negedge clk) begin
        ifq_entry_t e;
        logic       mv;
        if (!reset) begin
            mv = (exp_q.size() != 0);
            check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, mv});
            check("imem_a", bus.imem_a, model_pc);
            if (mv && bus.instr_ready) begin
                e = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, e.pc);
                check("instr", bus.instr, e.instr);
                $display("pop pc=%h instr=%h", bus.instr_pc, bus.instr);
            end
`ifdef IFETCH_QUEUE_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched[31:0]);
            check("perf_flushed", perf_flushed, m_flushed[31:0]);
`endif
        end
    end

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        @(negedge clk);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_imem_a", bus.imem_a, RESET_PC);
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Streaming from reset, then a stall that fills the FIFO.
        repeat (6) step(1'b1, 1'b0, '0);
        do_reset();
        repeat (10) step(1'b0, 1'b0, '0);
        check("stall_imem_a", bus.imem_a, 32'h10);
        repeat (8) step(1'b1, 1'b0, '0);

        // Asynchronous reset between edges while draining.
        repeat (3) step(1'b0, 1'b0, '0);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("async_rst_imem_a", bus.imem_a, RESET_PC);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Three queued, redirect to an unaligned target with a pop in the same cycle.
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h23);
        check("redir_imem_a", bus.imem_a, 32'h20);
        repeat (4) step(1'b1, 1'b0, '0);

        // Six fetches then a redirect with three queued and no pop.
        do_reset();
        repeat (3) step(1'b0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h100);
`ifdef IFETCH_QUEUE_PERF_EN
        check("perf_fetched_6", perf_fetched, 32'd6);
        check("perf_flushed_3", perf_flushed, 32'd3);
`endif
        repeat (3) step(1'b1, 1'b0, '0);

        // PC wrap at the top of the address space, plus back-to-back redirects.
        step(1'b1, 1'b1, 32'hFFFF_FFF6);
        repeat (5) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h81);
        repeat (3) step(1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, $urandom);
        end
        repeat (8) step(1'b1, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
